// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for Montgomery-domain modular exponentiation.
// It drives one external Montgomery multiplier through a start/done handshake.
module mont_exp_ctrl #(
  parameter int DATA_W = 512,
  parameter int EXP_W  = 512
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [DATA_W-1:0] in_x,
  input  logic [EXP_W-1:0]  in_e,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_m,
  output logic [DATA_W-1:0] result,
  output logic              done,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic [DATA_W-1:0] mul_m,
  input  logic [DATA_W-1:0] mul_result,
  input  logic              mul_done
);

  localparam int IDX_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SQR_REQ,
    SQR_WAIT,
    MUL_REQ,
    MUL_WAIT,
    NEXT,
    FIN
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [EXP_W-1:0]  e_q, e_d;
  logic [DATA_W-1:0] m_q, m_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] result_q, result_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= IDLE;
      x_q      <= '0;
      e_q      <= '0;
      m_q      <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      e_q      <= e_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets a hold default first so no path through the
    // case statement can infer a latch.
    state_d  = state_q;
    x_d      = x_q;
    e_d      = e_q;
    m_d      = m_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          x_d     = in_x;
          e_d     = in_e;
          m_d     = in_m;
          acc_d   = in_r;
          idx_d   = IDX_W'(EXP_W - 1);
          state_d = SCAN;
        end
      end

      // Skip leading zeros; the first set bit seeds the accumulator with X.
      SCAN: begin
        if (e_q[idx_q]) begin
          acc_d = x_q;
          if (idx_q == '0) begin
            state_d = FIN;
          end else begin
            idx_d   = idx_q - IDX_W'(1);
            state_d = SQR_REQ;
          end
        end else if (idx_q == '0) begin
          state_d = FIN;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end

      SQR_REQ: state_d = SQR_WAIT;

      SQR_WAIT: begin
        if (mul_done) begin
          acc_d   = mul_result;
          state_d = e_q[idx_q] ? MUL_REQ : NEXT;
        end
      end

      MUL_REQ: state_d = MUL_WAIT;

      MUL_WAIT: begin
        if (mul_done) begin
          acc_d   = mul_result;
          state_d = NEXT;
        end
      end

      NEXT: begin
        if (idx_q == '0) begin
          state_d = FIN;
        end else begin
          idx_d   = idx_q - IDX_W'(1);
          state_d = SQR_REQ;
        end
      end

      FIN: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    // Capturing on entry to FIN makes result valid in the same cycle done pulses.
    if (state_d == FIN) begin
      result_d = acc_d;
    end
  end

  assign done      = (state_q == FIN);
  assign mul_start = (state_q == SQR_REQ) || (state_q == MUL_REQ);
  assign mul_a     = acc_q;
  assign mul_b     = ((state_q == MUL_REQ) || (state_q == MUL_WAIT)) ? x_q : acc_q;
  assign mul_m     = m_q;
  assign result    = result_q;

endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Self-checking bench for mont_exp_ctrl: mock multiplier ((a*b) mod m after 5 cycles)
// plus a plain-arithmetic power model, with directed and randomized exponentiation runs.
module tb_mont_exp_ctrl;

  localparam int DATA_W = 16;
  localparam int EXP_W  = 8;
  localparam int MUL_LAT = 5;
  localparam int LIMIT  = 5000;

  logic              clk;
  logic              resetn;
  logic              start;
  logic [DATA_W-1:0] in_x;
  logic [EXP_W-1:0]  in_e;
  logic [DATA_W-1:0] in_r;
  logic [DATA_W-1:0] in_m;
  logic [DATA_W-1:0] result;
  logic              done;
  logic              mul_start;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic [DATA_W-1:0] mul_m;
  logic [DATA_W-1:0] mul_result;
  logic              mul_done;

  logic              mock_done;
  logic              spur_done;
  logic [DATA_W-1:0] mock_res;

  int tests;
  int fails;
  int n_req;
  logic [31:0] log_a[$];
  logic [31:0] log_b[$];

  mont_exp_ctrl #(.DATA_W(DATA_W), .EXP_W(EXP_W)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .in_x       (in_x),
    .in_e       (in_e),
    .in_r       (in_r),
    .in_m       (in_m),
    .result     (result),
    .done       (done),
    .mul_start  (mul_start),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_m      (mul_m),
    .mul_result (mul_result),
    .mul_done   (mul_done)
  );

  assign mul_done   = mock_done | spur_done;
  assign mul_result = mock_res;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Mock multiplier, evaluated mid-cycle so it never races the DUT's edge.
  logic        pend;
  int          cnt;
  logic [31:0] cap_a, cap_b, cap_m;

  always @(negedge clk) begin
    if (!resetn) begin
      pend      = 1'b0;
      mock_done = 1'b0;
    end else if (pend) begin
      check("stable_a", 32'(mul_a), cap_a);
      check("stable_b", 32'(mul_b), cap_b);
      check("stable_m", 32'(mul_m), cap_m);
      check("one_outstanding", 32'(mul_start), 32'd0);
      cnt--;
      if (cnt == 0) begin
        mock_done = 1'b1;
        mock_res  = DATA_W'((cap_a * cap_b) % cap_m);
        pend      = 1'b0;
      end
    end else begin
      mock_done = 1'b0;
      if (mul_start) begin
        cap_a = 32'(mul_a);
        cap_b = 32'(mul_b);
        cap_m = 32'(mul_m);
        log_a.push_back(cap_a);
        log_b.push_back(cap_b);
        pend  = 1'b1;
        cnt   = MUL_LAT;
        n_req++;
      end
    end
  end

  function automatic logic [31:0] model_pow(input int unsigned x, e, r, m);
    longint unsigned acc;
    if (e == 0) return r;
    acc = 1;
    for (int i = 0; i < e; i++) acc = (acc * x) % m;
    return 32'(acc);
  endfunction

  function automatic int model_calls(input int unsigned e);
    int bl, pc;
    bl = 0;
    pc = 0;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) begin
        bl = i + 1;
        pc++;
      end
    end
    return (e == 0) ? 0 : (bl - 1) + (pc - 1);
  endfunction

  task automatic kick(input int unsigned x, e, r, m);
    in_x  = DATA_W'(x);
    in_e  = EXP_W'(e);
    in_r  = DATA_W'(r);
    in_m  = DATA_W'(m);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic run(input string tag, input int unsigned x, e, r, m, input int lat);
    int cyc;
    n_req = 0;
    log_a.delete();
    log_b.delete();
    kick(x, e, r, m);
    wait_done(cyc);
    check({tag, "_result"}, 32'(result), model_pow(x, e, r, m));
    check({tag, "_calls"}, 32'(n_req), 32'(model_calls(e)));
    if (lat > 0) check({tag, "_latency"}, 32'(cyc), 32'(lat));
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int unsigned x, e, r, m;
    logic [31:0] held;
    int guard;
    tests     = 0;
    fails     = 0;
    n_req     = 0;
    spur_done = 1'b0;
    mock_done = 1'b0;
    mock_res  = '0;
    start     = 1'b0;
    in_x      = '0;
    in_e      = '0;
    in_r      = '0;
    in_m      = '0;
    resetn    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_mul_start", 32'(mul_start), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_mul_a", 32'(mul_a), 32'd0);
    check("rst_mul_m", 32'(mul_m), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // 3^5 mod 7: square, square, multiply with accumulator trace 3 -> 2 -> 4 -> 5.
    run("t1", 3, 5, 1, 7, 0);
    check("t1_result_const", 32'(result), 32'd5);
    check("t1_nreq", 32'(log_a.size()), 32'd3);
    if (log_a.size() == 3) begin
      check("t1_a0", log_a[0], 32'd3);
      check("t1_b0", log_b[0], 32'd3);
      check("t1_a1", log_a[1], 32'd2);
      check("t1_b1", log_b[1], 32'd2);
      check("t1_a2", log_a[2], 32'd4);
      check("t1_b2", log_b[2], 32'd3);
    end

    run("t2_e0", 3, 0, 1, 7, EXP_W + 1);
    run("t3_e1", 6, 1, 1, 7, EXP_W + 1);
    run("t4_ones", 2, 255, 1, 11, 0);
    check("t4_result_const", 32'(result), 32'd10);

    // Start pulsed during MUL_WAIT is ignored.
    n_req = 0;
    kick(5, 3, 1, 13);
    guard = 0;
    while (n_req < 2 && guard < LIMIT) begin
      @(posedge clk); #1;
      guard++;
    end
    check("t5_reach_mul", 32'(n_req), 32'd2);
    kick(7, 200, 1, 11);
    begin
      int cyc;
      wait_done(cyc);
    end
    check("t5_result", 32'(result), model_pow(5, 3, 1, 13));
    check("t5_calls", 32'(n_req), 32'd2);
    held = 32'(result);
    @(posedge clk); #1;

    // Spurious mul_done while idle.
    mock_res  = DATA_W'(16'hBEEF);
    spur_done = 1'b1;
    @(posedge clk); #1;
    spur_done = 1'b0;
    repeat (3) begin
      check("t5_idle_done", 32'(done), 32'd0);
      check("t5_idle_start", 32'(mul_start), 32'd0);
      @(posedge clk); #1;
    end
    check("t5_held", 32'(result), held);
    check("t5_no_calls", 32'(n_req), 32'd2);

    // Reset in the middle of SQR_WAIT.
    n_req = 0;
    kick(4, 200, 1, 9);
    guard = 0;
    while (n_req < 1 && guard < LIMIT) begin
      @(posedge clk); #1;
      guard++;
    end
    check("t6_reach_sqr", 32'(n_req), 32'd1);
    @(posedge clk); #1;
    resetn = 1'b0;
    @(posedge clk); #1;
    check("t6_done", 32'(done), 32'd0);
    check("t6_mul_start", 32'(mul_start), 32'd0);
    check("t6_result", 32'(result), 32'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    run("t6_rerun", 4, 200, 1, 9, 0);

    // Randomized runs against the power model.
    for (int i = 0; i < 10; i++) begin
      m = $urandom_range(4000, 3) | 32'd1;
      x = $urandom_range(m - 1, 0);
      r = $urandom_range(m - 1, 0);
      e = $urandom_range(255, 0);
      run($sformatf("rnd%0d", i), x, e, r, m, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
